stch_output_decoder: RTL and testbench

- Sits directly downstream of the forward-propagation block and consumes the output-layer stochastic bitstream a_L3, one bit per output neuron per clock.
- Counts the ones per neuron over a fixed observation window, converting each stream to a binary probability estimate.
- Then selects the winning class with a sequential argmax.
- Delivers counts and class index through a valid/ready handshake to the host/readout logic.

---
 rtl/stch_nn_pkg.sv | 21 ++
 rtl/stch_ones_counter.sv | 34 +++
 rtl/stch_output_decoder.sv | 136 +++++++++++++
 tb/tb_stch_output_decoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stch_nn_pkg.sv
// Shared types and width helpers for the stochastic-NN readout blocks.
package stch_nn_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, HOLD} stch_state_e;

  localparam int N_OUT_DEF       = 5;
  localparam int WINDOW_LOG2_DEF = 8;

  // Count must hold 0..2**window_log2 inclusive, hence one extra bit.
  function automatic int stch_cnt_w(input int window_log2);
    return window_log2 + 1;
  endfunction

  function automatic int stch_idx_w(input int n_out);
    int w;
    w = 1;
    while ((1 << w) < n_out) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/stch_ones_counter.sv
// Ones counter for one stochastic bitstream; 1-cycle update, clear has priority over enable.
module stch_ones_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/stch_output_decoder.sv
// Window ones-count per output neuron, then sequential argmax; result after W enabled samples + N_OUT-1 cycles.
// Result is held in HOLD with out_valid until out_ready; no new window starts until it is taken.
module stch_output_decoder
  import stch_nn_pkg::*;
#(
  parameter int N_OUT       = N_OUT_DEF,
  parameter int WINDOW_LOG2 = WINDOW_LOG2_DEF,
  parameter int CNT_W       = stch_cnt_w(WINDOW_LOG2),
  parameter int IDX_W       = stch_idx_w(N_OUT)
) (
  input  logic                   CLK,
  input  logic                   INIT,
  input  logic                   start,
  input  logic                   EN,
  input  logic [N_OUT-1:0]       a_L3,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_OUT*CNT_W-1:0] counts,
  output logic [IDX_W-1:0]       class_idx,
  output logic                   tie
);

  localparam int W = 1 << WINDOW_LOG2;

  stch_state_e      state_q, state_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [IDX_W-1:0] cmp_q, cmp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic             tie_q, tie_d;

  logic [CNT_W-1:0] cnt [N_OUT];
  logic             cnt_clr, cnt_en;
  logic [CNT_W-1:0] cur_cnt, base_cnt;
  logic [IDX_W-1:0] base_idx;
  logic             base_tie, first_cmp;

  for (genvar gk = 0; gk < N_OUT; gk++) begin : g_cnt
    stch_ones_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (CLK),
      .rst    (INIT),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .bit_in (a_L3[gk]),
      .cnt    (cnt[gk])
    );
    assign counts[gk*CNT_W +: CNT_W] = cnt[gk];
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cmp_d   = cmp_q;
    idx_d   = idx_q;
    best_d  = best_q;
    tie_d   = tie_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    cur_cnt = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (cmp_q == IDX_W'(k)) cur_cnt = cnt[k];
    end
    // The first compare seeds the running best from neuron 0 directly.
    first_cmp = (cmp_q == IDX_W'(1));
    base_cnt  = first_cmp ? cnt[0] : best_q;
    base_idx  = first_cmp ? '0     : idx_q;
    base_tie  = first_cmp ? 1'b0   : tie_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          win_d   = '0;
          idx_d   = '0;
          tie_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (EN) begin
          cnt_en = 1'b1;
          win_d  = win_q + CNT_W'(1);
          if (win_q == CNT_W'(W - 1)) begin
            cmp_d   = IDX_W'(1);
            state_d = ARGMAX;
          end
        end
      end
      ARGMAX: begin
        if (cur_cnt > base_cnt) begin
          best_d = cur_cnt;
          idx_d  = cmp_q;
          tie_d  = 1'b0;
        end else begin
          best_d = base_cnt;
          idx_d  = base_idx;
          tie_d  = base_tie | (cur_cnt == base_cnt);
        end
        if (cmp_q == IDX_W'(N_OUT - 1)) begin
          state_d = HOLD;
        end else begin
          cmp_d = cmp_q + IDX_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_q <= IDLE;
      win_q   <= '0;
      cmp_q   <= '0;
      idx_q   <= '0;
      best_q  <= '0;
      tie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cmp_q   <= cmp_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      tie_q   <= tie_d;
    end
  end

  assign busy      = (state_q == ACCUM) || (state_q == ARGMAX);
  assign out_valid = (state_q == HOLD);
  assign class_idx = idx_q;
  assign tie       = tie_q;

endmodule

// File: tb/tb_stch_output_decoder.sv
// Randomized bench for stch_output_decoder against a window/argmax reference model.
module tb_stch_output_decoder;

  localparam int N_OUT = 5;
  localparam int W     = 256;
  localparam int CNT_W = 9;
  localparam int IDX_W = 3;

  logic                   CLK = 1'b0;
  logic                   INIT = 1'b1;
  logic                   start = 1'b0;
  logic                   EN = 1'b0;
  logic                   out_ready = 1'b0;
  logic [N_OUT-1:0]       a_L3 = '0;
  logic                   busy, out_valid, tie;
  logic [N_OUT*CNT_W-1:0] counts;
  logic [IDX_W-1:0]       class_idx;

  stch_output_decoder dut (
    .CLK       (CLK),
    .INIT      (INIT),
    .start     (start),
    .EN        (EN),
    .a_L3      (a_L3),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .counts    (counts),
    .class_idx (class_idx),
    .tie       (tie)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 collecting, 2 deciding, 3 result offered.
  int probs [N_OUT] = '{100, 300, 900, 500, 200};
  int m_phase = 0;
  int m_samp  = 0;
  int m_wait  = 0;
  int m_cnt [N_OUT] = '{0, 0, 0, 0, 0};
  int m_idx = 0;
  bit m_tie = 1'b0;

  task automatic m_decide();
    int best, nbest;
    best = -1;
    for (int k = 0; k < N_OUT; k++) begin
      if (m_cnt[k] > best) begin
        best  = m_cnt[k];
        m_idx = k;
      end
    end
    nbest = 0;
    for (int k = 0; k < N_OUT; k++) if (m_cnt[k] == best) nbest++;
    m_tie = (nbest > 1);
  endtask

  function automatic logic [N_OUT*CNT_W-1:0] m_counts();
    logic [N_OUT*CNT_W-1:0] r;
    for (int k = 0; k < N_OUT; k++) r[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
    return r;
  endfunction

  always @(posedge CLK) begin
    if (INIT) begin
      m_phase = 0;
      for (int k = 0; k < N_OUT; k++) m_cnt[k] = 0;
      m_idx = 0;
      m_tie = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          for (int k = 0; k < N_OUT; k++) m_cnt[k] = 0;
          m_samp  = 0;
          m_phase = 1;
        end
        1: if (EN) begin
          for (int k = 0; k < N_OUT; k++) m_cnt[k] += int'(a_L3[k]);
          m_samp++;
          if (m_samp == W) begin
            m_phase = 2;
            m_wait  = 0;
          end
        end
        2: begin
          m_wait++;
          if (m_wait == N_OUT - 1) begin
            m_decide();
            m_phase = 3;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  bit chk_on = 1'b0;

  always @(negedge CLK) begin
    if (chk_on) begin
      check("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
      check("out_valid", 64'(out_valid), 64'(m_phase == 3));
      check("counts", 64'(counts), 64'(m_counts()));
      if (m_phase == 0 || m_phase == 3) begin
        check("class_idx", 64'(class_idx), 64'(m_idx));
        check("tie", 64'(tie), 64'(m_tie));
      end
    end
  end

  function automatic logic [N_OUT-1:0] gen_bits(input int mode, input logic [N_OUT-1:0] pat);
    logic [N_OUT-1:0] r;
    r = pat;
    if (mode == 1) begin
      for (int k = 0; k < N_OUT; k++) r[k] = ($urandom_range(999) < probs[k]);
    end
    return r;
  endfunction

  task automatic run_to_hold(input int mode, input logic [N_OUT-1:0] pat, input bit en_tog,
                             input bit stray, output int lat);
    bit done;
    done = 1'b0;
    @(posedge CLK); #1;
    start = 1'b1; EN = 1'b1; out_ready = 1'b0; a_L3 = gen_bits(mode, pat);
    lat = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge CLK); lat++; #1;
      start = stray ? 1'($urandom_range(1)) : 1'b0;
      EN    = en_tog ? (c % 2 == 0) : 1'b1;
      a_L3  = gen_bits(mode, pat);
      @(negedge CLK);
      if (out_valid) done = 1'b1;
    end
    check("hold_reached", 64'(done), 64'd1);
  endtask

  task automatic release_hold(input int n, input bit stray);
    logic [N_OUT*CNT_W-1:0] held_counts;
    logic [IDX_W-1:0]       held_idx;
    held_counts = counts;
    held_idx    = class_idx;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      start = stray ? 1'($urandom_range(1)) : 1'b0;
      out_ready = 1'b0;
      @(negedge CLK);
      check("hold_counts_stable", 64'(counts), 64'(held_counts));
      check("hold_idx_stable", 64'(class_idx), 64'(held_idx));
      check("hold_valid", 64'(out_valid), 64'd1);
    end
    @(posedge CLK); #1;
    start = 1'b0; out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    @(negedge CLK);
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_busy", 64'(busy), 64'd0);
  endtask

  int lat;

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_counts", 64'(counts), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_idx", 64'(class_idx), 64'd0);
    check("rst_tie", 64'(tie), 64'd0);
    chk_on = 1'b1;
    @(posedge CLK); #1;
    INIT = 1'b0;

    // Single hot neuron: latency and result.
    run_to_hold(0, 5'b00100, 1'b0, 1'b0, lat);
    check("t1_latency", 64'(lat), 64'd261);
    check("t1_counts", 64'(counts), 64'({9'd0, 9'd0, 9'd256, 9'd0, 9'd0}));
    check("t1_idx", 64'(class_idx), 64'd2);
    check("t1_tie", 64'(tie), 64'd0);
    release_hold(0, 1'b0);

    // Two equal winners: lowest index, tie flagged.
    run_to_hold(0, 5'b01010, 1'b0, 1'b0, lat);
    check("t2_counts", 64'(counts), 64'({9'd0, 9'd256, 9'd0, 9'd256, 9'd0}));
    check("t2_idx", 64'(class_idx), 64'd1);
    check("t2_tie", 64'(tie), 64'd1);
    release_hold(0, 1'b0);

    // Half-rate enable stretches the window.
    run_to_hold(0, 5'b11111, 1'b1, 1'b0, lat);
    check("t3_latency", 64'(lat), 64'd516);
    check("t3_counts", 64'(counts), 64'({5{9'd256}}));
    check("t3_idx", 64'(class_idx), 64'd0);
    check("t3_tie", 64'(tie), 64'd1);
    release_hold(0, 1'b0);

    // Bernoulli streams.
    run_to_hold(1, 5'b00000, 1'b0, 1'b0, lat);
    check("t4_idx", 64'(class_idx), 64'd2);
    release_hold(3, 1'b0);

    // Reset mid-window, then a clean window.
    @(posedge CLK); #1;
    start = 1'b1; EN = 1'b1; a_L3 = gen_bits(1, 5'b0);
    for (int c = 0; c < 100; c++) begin
      @(posedge CLK); #1;
      start = 1'b0; a_L3 = gen_bits(1, 5'b0);
    end
    INIT = 1'b1;
    @(posedge CLK); #1;
    INIT = 1'b0;
    @(negedge CLK);
    check("t5_rst_counts", 64'(counts), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    run_to_hold(0, 5'b00001, 1'b0, 1'b0, lat);
    check("t5_counts", 64'(counts), 64'({9'd0, 9'd0, 9'd0, 9'd0, 9'd256}));
    check("t5_idx", 64'(class_idx), 64'd0);
    check("t5_tie", 64'(tie), 64'd0);
    release_hold(0, 1'b0);

    // Stray starts everywhere, backpressure in HOLD.
    run_to_hold(0, 5'b10000, 1'b0, 1'b1, lat);
    check("t6_latency", 64'(lat), 64'd261);
    check("t6_counts", 64'(counts), 64'({9'd256, 9'd0, 9'd0, 9'd0, 9'd0}));
    check("t6_idx", 64'(class_idx), 64'd4);
    release_hold(20, 1'b1);

    repeat (2) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
